// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/command bus and HI/LO/busy results of the EX-stage multiply/divide unit.
interface mult_div_unit_if;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, md_op, A, B,
      input  busy, md_stall, HI, LO
   );

   modport slave (
      input  start, md_op, A, B,
      output busy, md_stall, HI, LO
   );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit holding HI/LO with a fixed-latency busy counter.
// Optional feature macro MD_MADD_EN enables madd/maddu (HI:LO accumulate).
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t      state_r, state_n;
   logic [3:0]  cnt_r, cnt_n;
   logic [3:0]  op_r, op_n;
   logic [31:0] a_r, a_n, b_r, b_n;
   logic [31:0] hi_r, hi_n, lo_r, lo_n;
   logic        busy_s;
   logic [63:0] smul_s, umul_s;
   logic [31:0] udiv_b_s, udiv_q_s, udiv_r_s;
   logic [31:0] abs_a_s, abs_b_s, sdiv_b_s, sq_mag_s, sr_mag_s, sdiv_q_s, sdiv_r_s;

   function automatic logic is_mult_op(input logic [3:0] op);
      logic r;
      case (op)
         OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MD_MADD_EN
         OP_MADD, OP_MADDU: r = 1'b1;
`endif
         default:           r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_md_op(input logic [3:0] op);
      return is_mult_op(op) | (op == OP_DIV) | (op == OP_DIVU);
   endfunction

   assign smul_s = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
   assign umul_s = {32'd0, a_r} * {32'd0, b_r};

   // Divisors are forced non-zero so the dividers never see 0; results are discarded for B=0.
   assign udiv_b_s = (b_r == 32'd0) ? 32'd1 : b_r;
   assign udiv_q_s = a_r / udiv_b_s;
   assign udiv_r_s = a_r % udiv_b_s;

   // Signed divide on magnitudes: 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
   assign abs_a_s  = a_r[31] ? (32'd0 - a_r) : a_r;
   assign abs_b_s  = b_r[31] ? (32'd0 - b_r) : b_r;
   assign sdiv_b_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
   assign sq_mag_s = abs_a_s / sdiv_b_s;
   assign sr_mag_s = abs_a_s % sdiv_b_s;
   assign sdiv_q_s = (a_r[31] ^ b_r[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
   assign sdiv_r_s = a_r[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

   assign busy_s       = (state_r == ST_BUSY);
   assign bus.busy     = busy_s;
   assign bus.HI       = hi_r;
   assign bus.LO       = lo_r;
   assign bus.md_stall = busy_s | (bus.start & is_md_op(bus.md_op));

   // Next-state, counter, operand latch and HI/LO update logic.
   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      op_n    = op_r;
      a_n     = a_r;
      b_n     = b_r;
      hi_n    = hi_r;
      lo_n    = lo_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start && is_md_op(bus.md_op)) begin
               op_n    = bus.md_op;
               a_n     = bus.A;
               b_n     = bus.B;
               cnt_n   = is_mult_op(bus.md_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
               state_n = ST_BUSY;
            end else if (bus.start && (bus.md_op == OP_MTHI)) begin
               hi_n = bus.A;
            end else if (bus.start && (bus.md_op == OP_MTLO)) begin
               lo_n = bus.A;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == 4'd1) begin
               cnt_n   = 4'd0;
               state_n = ST_IDLE;
               case (op_r)
                  OP_MULT:  {hi_n, lo_n} = smul_s;
                  OP_MULTU: {hi_n, lo_n} = umul_s;
                  OP_DIV: begin
                     if (b_r != 32'd0) begin
                        hi_n = sdiv_r_s;
                        lo_n = sdiv_q_s;
                     end else begin
                        hi_n = hi_r;
                        lo_n = lo_r;
                     end
                  end
                  OP_DIVU: begin
                     if (b_r != 32'd0) begin
                        hi_n = udiv_r_s;
                        lo_n = udiv_q_s;
                     end else begin
                        hi_n = hi_r;
                        lo_n = lo_r;
                     end
                  end
`ifdef MD_MADD_EN
                  OP_MADD:  {hi_n, lo_n} = {hi_r, lo_r} + smul_s;
                  OP_MADDU: {hi_n, lo_n} = {hi_r, lo_r} + umul_s;
`endif
                  default: begin
                     hi_n = hi_r;
                     lo_n = lo_r;
                  end
               endcase
            end else begin
               cnt_n = cnt_r - 4'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // State, counter, operand latch and HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         op_r    <= 4'd0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         op_r    <= op_n;
         a_r     <= a_n;
         b_r     <= b_n;
         hi_r    <= hi_n;
         lo_r    <= lo_n;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit (default latencies 5/10).
// Define MD_MADD_EN for both bench and RTL to exercise madd/maddu.
module tb_mult_div_unit;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;

   mult_div_unit_if u_if ();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      u_if.start = s;
      u_if.md_op = op;
      u_if.A     = a;
      u_if.B     = b;
   endtask

   // Issue on one edge, then return the number of cycles busy is seen high (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
      drive(1'b1, op, a, b);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n = 0;
      while (u_if.busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      tick();
      check("reset_busy", {63'd0, u_if.busy}, 64'd0);
      check("reset_hilo", {u_if.HI, u_if.LO}, 64'd0);
      rst_n = 1'b1;
      tick();

      // mult -2 * 3
      drive(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
      #1;
      check("mult_stall_comb", {63'd0, u_if.md_stall}, 64'd1);
      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
      check("mult_busy_cycles", 64'(cyc), 64'd5);
      check("mult_hilo", {u_if.HI, u_if.LO}, 64'hFFFF_FFFF_FFFF_FFFA);

      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      check("multu_busy_cycles", 64'(cyc), 64'd5);
      check("multu_hilo", {u_if.HI, u_if.LO}, 64'hFFFF_FFFE_0000_0001);

      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
      check("div_busy_cycles", 64'(cyc), 64'd10);
      check("div_hilo", {u_if.HI, u_if.LO}, 64'hFFFF_FFFF_FFFF_FFFD);

      run_op(4'd4, 32'd7, 32'd0, cyc);
      check("divu_zero_cycles", 64'(cyc), 64'd10);
      check("divu_zero_hilo", {u_if.HI, u_if.LO}, 64'hFFFF_FFFF_FFFF_FFFD);

      run_op(4'd4, 32'd100, 32'd7, cyc);
      check("divu_hilo", {u_if.HI, u_if.LO}, {32'd2, 32'd14});

      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      check("div_ovf_hilo", {u_if.HI, u_if.LO}, 64'h0000_0000_8000_0000);

      run_op(4'd3, 32'd7, 32'hFFFF_FFFE, cyc);
      check("div_negdivisor_hilo", {u_if.HI, u_if.LO}, 64'h0000_0001_FFFF_FFFD);

      // mthi then mtlo on consecutive edges
      drive(1'b1, 4'd5, 32'h1234_5678, 32'd0);
      #1;
      check("mthi_stall", {63'd0, u_if.md_stall}, 64'd0);
      tick();
      check("mthi_hilo", {u_if.HI, u_if.LO}, 64'h1234_5678_FFFF_FFFD);
      drive(1'b1, 4'd6, 32'h9ABC_DEF0, 32'd0);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("mtlo_hilo", {u_if.HI, u_if.LO}, 64'h1234_5678_9ABC_DEF0);
      check("mtlo_busy", {63'd0, u_if.busy}, 64'd0);

      // mult with operand churn and an mthi re-pulse while busy
      drive(1'b1, 4'd1, 32'd3, 32'd4);
      tick();
      drive(1'b0, 4'd0, 32'hAAAA_5555, 32'h5555_AAAA);
      tick();
      drive(1'b1, 4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      #1;
      check("busy_stall", {63'd0, u_if.md_stall}, 64'd1);
      tick();
      drive(1'b0, 4'd0, 32'h1111_1111, 32'h2222_2222);
      check("mid_op_hilo", {u_if.HI, u_if.LO}, 64'h1234_5678_9ABC_DEF0);
      cyc = 0;
      while (u_if.busy === 1'b1 && cyc < 40) begin
         cyc++;
         tick();
      end
      check("ignored_start_cycles", 64'(cyc), 64'd3);
      check("ignored_start_hilo", {u_if.HI, u_if.LO}, 64'h0000_0000_0000_000C);

      // none and undefined codes
      drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
      #1;
      check("none_stall", {63'd0, u_if.md_stall}, 64'd0);
      tick();
      drive(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("undef_busy", {63'd0, u_if.busy}, 64'd0);
      check("undef_hilo", {u_if.HI, u_if.LO}, 64'h0000_0000_0000_000C);

      // asynchronous reset at busy cycle 3 of a div
      drive(1'b1, 4'd3, 32'd100, 32'd7);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      tick();
      check("pre_reset_busy", {63'd0, u_if.busy}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_busy", {63'd0, u_if.busy}, 64'd0);
      check("async_reset_hilo", {u_if.HI, u_if.LO}, 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("post_reset_busy", {63'd0, u_if.busy}, 64'd0);
      check("post_reset_hilo", {u_if.HI, u_if.LO}, 64'd0);

      // madd/maddu accumulate, or ignored when the feature is off
      drive(1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0);
      tick();
      drive(1'b1, 4'd8, 32'd1, 32'd1);
      #1;
`ifdef MD_MADD_EN
      check("maddu_stall", {63'd0, u_if.md_stall}, 64'd1);
      run_op(4'd8, 32'd1, 32'd1, cyc);
      check("maddu_cycles", 64'(cyc), 64'd5);
      check("maddu_hilo", {u_if.HI, u_if.LO}, 64'h0000_0001_0000_0000);
      run_op(4'd7, 32'hFFFF_FFFF, 32'd1, cyc);
      check("madd_hilo", {u_if.HI, u_if.LO}, 64'h0000_0000_FFFF_FFFF);
`else
      check("maddu_off_stall", {63'd0, u_if.md_stall}, 64'd0);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("maddu_off_busy", {63'd0, u_if.busy}, 64'd0);
      tick();
      check("maddu_off_hilo", {u_if.HI, u_if.LO}, 64'h0000_0000_FFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
